// File: rtl/flash_therm_encoder_pkg.sv
// Shared helpers for the flash thermometer encoder: comparator-count
// derivation, legality test, popcount and the legal parameter ranges.
package flash_therm_encoder_pkg;

  localparam int unsigned MAX_N_BITS      = 8;
  localparam int unsigned MAX_COMP        = (32'd1 << MAX_N_BITS) - 32'd1;
  localparam int unsigned SYNC_STAGES_MIN = 2;
  localparam int unsigned SYNC_STAGES_MAX = 4;
  localparam int unsigned AVG_LOG2_MAX    = 4;

  // Widest thermometer word any instance can carry; narrower words are
  // zero-extended into it before the helpers below are applied.
  typedef logic [MAX_COMP-1:0] therm_word_t;

  function automatic int unsigned n_comp(input int unsigned n_bits);
    return (32'd1 << n_bits) - 32'd1;
  endfunction

  function automatic int unsigned popcount(input therm_word_t w);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < int'(MAX_COMP); i++) begin
      cnt = cnt + 32'(w[i]);
    end
    return cnt;
  endfunction

  // A word of the form 2^k - 1 has no set bit that survives w & (w + 1).
  function automatic logic is_thermometer(input therm_word_t w);
    return (w & (w + therm_word_t'(1))) == '0;
  endfunction

endpackage

// File: rtl/flash_therm_encoder_bubble_fix.sv
// Combinational single-bubble corrector: majority-of-3 over each bit and its
// neighbours, plus a flag for words that are not a clean thermometer code.
module therm_bubble_fix
  import flash_therm_encoder_pkg::*;
#(
  parameter int unsigned N_COMP = 15
) (
  input  logic [N_COMP-1:0] i_therm,
  input  logic              i_bubble_en,
  output logic [N_COMP-1:0] o_fixed,
  output logic              o_illegal
);

  // Implied 1 below the lowest comparator and 0 above the highest.
  logic [N_COMP+1:0] w_ext;
  therm_word_t       w_wide;

  assign w_ext     = {1'b0, i_therm, 1'b1};
  assign w_wide    = therm_word_t'(i_therm);
  assign o_illegal = ~is_thermometer(w_wide);

  // Vote each bit with its two neighbours when correction is enabled.
  always_comb begin
    o_fixed = i_therm;
    if (i_bubble_en) begin
      for (int i = 0; i < int'(N_COMP); i++) begin
        o_fixed[i] = (w_ext[i] & w_ext[i+1]) | (w_ext[i+1] & w_ext[i+2]) |
                     (w_ext[i] & w_ext[i+2]);
      end
    end
  end

endmodule

// File: rtl/flash_therm_encoder.sv
// Flash-ADC thermometer encoder: synchroniser, capture, bubble fix + encode,
// optional block averaging, and a saturating bubble-error counter.
module flash_therm_encoder
  import flash_therm_encoder_pkg::*;
#(
  parameter  int unsigned N_BITS      = 4,
  parameter  int unsigned SYNC_STAGES = 2,
  parameter  int unsigned AVG_LOG2    = 0,
  parameter  int unsigned ERR_W       = 8,
  localparam int unsigned N_COMP      = n_comp(N_BITS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_COMP-1:0] therm_in,
  input  logic              sample_en,
  input  logic              bubble_en,
  input  logic              clr,
  output logic [N_BITS-1:0] code_out,
  output logic              code_valid,
  output logic              bubble_err,
  output logic [ERR_W-1:0]  err_count
);

  if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
    $error("flash_therm_encoder: SYNC_STAGES out of range");
  end
  if (AVG_LOG2 > AVG_LOG2_MAX) begin : g_bad_avg
    $error("flash_therm_encoder: AVG_LOG2 out of range");
  end
  if (N_BITS > MAX_N_BITS) begin : g_bad_bits
    $error("flash_therm_encoder: N_BITS too wide");
  end

  logic [N_COMP-1:0]      r_sync [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] r_sync_vld;
  logic [N_COMP-1:0]      r_cap;
  logic                   r_cap_vld;
  logic [N_COMP-1:0]      w_fixed;
  logic                   w_illegal;
  logic [N_BITS-1:0]      r_c_code;
  logic                   r_c_vld;
  logic                   r_bubble_err;
  logic [ERR_W-1:0]       r_err_count;
  logic [N_BITS-1:0]      r_code_out;
  logic                   r_code_valid;

  // Metastability chain; data runs freely, only the valids qualify it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= therm_in;
      for (int i = 1; i < int'(SYNC_STAGES); i++) r_sync[i] <= r_sync[i-1];
    end
  end

  // Valid chain matching the data chain; clr drops everything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   r_sync_vld <= '0;
    else if (clr) r_sync_vld <= '0;
    else          r_sync_vld <= {r_sync_vld[SYNC_STAGES-2:0], sample_en};
  end

  // Hold the synchronised sample so the corrector only toggles on real samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cap     <= '0;
      r_cap_vld <= 1'b0;
    end else begin
      r_cap_vld <= r_sync_vld[SYNC_STAGES-1] & ~clr;
      if (r_sync_vld[SYNC_STAGES-1]) r_cap <= r_sync[SYNC_STAGES-1];
    end
  end

  therm_bubble_fix #(.N_COMP(N_COMP)) u_fix (
    .i_therm     (r_cap),
    .i_bubble_en (bubble_en),
    .o_fixed     (w_fixed),
    .o_illegal   (w_illegal)
  );

  // Stage C: encode the corrected word and flag illegal raw words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_c_code     <= '0;
      r_c_vld      <= 1'b0;
      r_bubble_err <= 1'b0;
    end else begin
      r_c_vld      <= r_cap_vld & ~clr;
      r_bubble_err <= r_cap_vld & w_illegal & ~clr;
      if (r_cap_vld) r_c_code <= N_BITS'(popcount(therm_word_t'(w_fixed)));
    end
  end

  // Saturating bubble counter so calibration reads never wrap to small values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   r_err_count <= '0;
    else if (clr) r_err_count <= '0;
    else if (r_cap_vld && w_illegal && !(&r_err_count))
      r_err_count <= r_err_count + 1'b1;
  end

  if (AVG_LOG2 == 0) begin : g_pass
    // Stage O pass-through: register each code as it arrives.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_code_out   <= '0;
        r_code_valid <= 1'b0;
      end else begin
        r_code_valid <= r_c_vld & ~clr;
        if (r_c_vld && !clr) r_code_out <= r_c_code;
      end
    end
  end else begin : g_avg
    localparam int unsigned ACC_W = N_BITS + AVG_LOG2;

    logic [ACC_W-1:0]    r_acc;
    logic [AVG_LOG2-1:0] r_cnt;
    logic [ACC_W-1:0]    w_sum;

    assign w_sum = r_acc + ACC_W'(r_c_code);

    // Stage O averaging: the closing sample is folded in directly so the
    // block result needs no extra cycle and the accumulator restarts at 0.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_acc        <= '0;
        r_cnt        <= '0;
        r_code_out   <= '0;
        r_code_valid <= 1'b0;
      end else if (clr) begin
        r_acc        <= '0;
        r_cnt        <= '0;
        r_code_valid <= 1'b0;
      end else begin
        r_code_valid <= 1'b0;
        if (r_c_vld) begin
          if (&r_cnt) begin
            r_code_out   <= w_sum[ACC_W-1:AVG_LOG2];
            r_code_valid <= 1'b1;
            r_acc        <= '0;
            r_cnt        <= '0;
          end else begin
            r_acc <= w_sum;
            r_cnt <= r_cnt + 1'b1;
          end
        end
      end
    end
  end

  assign code_out   = r_code_out;
  assign code_valid = r_code_valid;
  assign bubble_err = r_bubble_err;
  assign err_count  = r_err_count;

endmodule

// File: tb/tb_flash_therm_encoder.sv
// Scoreboard bench: two encoder instances (pass-through with a 2-bit error
// counter, and 4-sample averaging) share one stimulus stream.
module tb_flash_therm_encoder;

  localparam int NC  = 15;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sample_en = 1'b0;
  logic          bubble_en = 1'b0;
  logic          clr = 1'b0;
  logic [NC-1:0] therm_in = '0;

  logic [3:0] p_code, a_code;
  logic       p_valid, a_valid, p_berr, a_berr;
  logic [1:0] p_err;
  logic [7:0] a_err;

  always #5 clk = ~clk;

  flash_therm_encoder #(.N_BITS(4), .SYNC_STAGES(2), .AVG_LOG2(0), .ERR_W(2)) u_pass (
    .clk(clk), .rst_n(rst_n), .therm_in(therm_in), .sample_en(sample_en),
    .bubble_en(bubble_en), .clr(clr), .code_out(p_code), .code_valid(p_valid),
    .bubble_err(p_berr), .err_count(p_err)
  );

  flash_therm_encoder #(.N_BITS(4), .SYNC_STAGES(2), .AVG_LOG2(2), .ERR_W(8)) u_avg (
    .clk(clk), .rst_n(rst_n), .therm_in(therm_in), .sample_en(sample_en),
    .bubble_en(bubble_en), .clr(clr), .code_out(a_code), .code_valid(a_valid),
    .bubble_err(a_berr), .err_count(a_err)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct { int issue; logic [NC-1:0] raw; int code; bit illegal; } smp_t;
  typedef struct { int due; int code; } exp_t;

  smp_t pipe_q[$];
  exp_t exp_pass[$];
  exp_t exp_avg[$];
  smp_t s;
  exp_t e;
  int   acc_sum = 0, acc_n = 0;
  int   exp_berr = 0, exp_err_p = 0, exp_err_a = 0;
  int   last_pass = 0, last_avg = 0;

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic logic [NC-1:0] therm_of(int k);
    logic [NC-1:0] t;
    t = '0;
    for (int i = 0; i < k; i++) t[i] = 1'b1;
    return t;
  endfunction

  function automatic bit ref_legal(logic [NC-1:0] w);
    for (int k = 0; k <= NC; k++) if (w == therm_of(k)) return 1'b1;
    return 1'b0;
  endfunction

  // Number of comparators reading 1 after the optional neighbour vote.
  function automatic int ref_code(logic [NC-1:0] w, bit fix);
    int n, below, above;
    n = 0;
    for (int i = 0; i < NC; i++) begin
      below = (i == 0) ? 1 : int'(w[i-1]);
      above = (i == NC-1) ? 0 : int'(w[i+1]);
      if (!fix) n += int'(w[i]);
      else if (below + int'(w[i]) + above >= 2) n++;
    end
    return n;
  endfunction

  function automatic logic [NC-1:0] rand_therm();
    logic [NC-1:0] w;
    int sel;
    sel = int'($urandom_range(0, 3));
    w = therm_of(int'($urandom_range(0, 15)));
    if (sel == 1) w[$urandom_range(0, NC-1)] ^= 1'b1;
    else if (sel == 2) w = NC'($urandom());
    return w;
  endfunction

  // Reference model: tracks samples by issue cycle and pushes expectations.
  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      pipe_q.delete(); exp_pass.delete(); exp_avg.delete();
      acc_sum = 0; acc_n = 0; exp_berr = 0; exp_err_p = 0; exp_err_a = 0;
      last_pass = 0; last_avg = 0;
    end else if (clr) begin
      pipe_q.delete();
      acc_sum = 0; acc_n = 0; exp_berr = 0; exp_err_p = 0; exp_err_a = 0;
    end else begin
      exp_berr = 0;
      if (pipe_q.size() > 0 && pipe_q[0].issue + LAT == cyc) begin
        s = pipe_q.pop_front();
        exp_pass.push_back('{cyc, s.code});
        acc_sum += s.code;
        acc_n++;
        if (acc_n == 4) begin
          exp_avg.push_back('{cyc, acc_sum / 4});
          acc_sum = 0;
          acc_n = 0;
        end
      end
      if (pipe_q.size() > 0 && pipe_q[0].issue + LAT - 1 == cyc) begin
        s = pipe_q[0];
        s.code = ref_code(s.raw, bubble_en);
        s.illegal = !ref_legal(s.raw);
        pipe_q[0] = s;
        if (s.illegal) begin
          exp_berr = 1;
          if (exp_err_p < 3) exp_err_p++;
          if (exp_err_a < 255) exp_err_a++;
        end
      end
      if (sample_en) pipe_q.push_back('{cyc, therm_in, 0, 0});
    end
  end

  // Monitor: pops an expectation whenever a DUT presents code_valid.
  always @(posedge clk) begin
    #1;
    if (p_valid) begin
      if (exp_pass.size() == 0) check("pass_unexpected_valid", 1, 0);
      else begin
        e = exp_pass.pop_front();
        check("pass_code", int'(p_code), e.code);
        last_pass = e.code;
      end
    end else check("pass_code_hold", int'(p_code), last_pass);
    while (exp_pass.size() > 0 && exp_pass[0].due <= cyc) begin
      check("pass_missed_valid", 0, 1);
      void'(exp_pass.pop_front());
    end
    if (a_valid) begin
      if (exp_avg.size() == 0) check("avg_unexpected_valid", 1, 0);
      else begin
        e = exp_avg.pop_front();
        check("avg_code", int'(a_code), e.code);
        last_avg = e.code;
      end
    end else check("avg_code_hold", int'(a_code), last_avg);
    while (exp_avg.size() > 0 && exp_avg[0].due <= cyc) begin
      check("avg_missed_valid", 0, 1);
      void'(exp_avg.pop_front());
    end
    check("pass_bubble_err", int'(p_berr), exp_berr);
    check("avg_bubble_err", int'(a_berr), exp_berr);
    check("pass_err_count", int'(p_err), exp_err_p);
    check("avg_err_count", int'(a_err), exp_err_a);
  end

  task automatic drive(logic [NC-1:0] w, bit en, bit c);
    @(negedge clk);
    therm_in = w;
    sample_en = en;
    clr = c;
  endtask

  task automatic idle(int n);
    repeat (n) drive(rand_therm(), 1'b0, 1'b0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    drive(15'h007F, 1, 0); idle(6);
    drive(15'h0000, 1, 0); drive(15'h7FFF, 1, 0); idle(6);
    for (int k = 0; k < 16; k++) drive(therm_of(k), 1, 0);
    idle(6);

    drive('0, 0, 1); idle(2);
    bubble_en = 1'b1;
    drive(15'b000000001011111, 1, 0); idle(6);
    bubble_en = 1'b0;
    drive(15'b000000001011111, 1, 0); idle(6);

    drive('0, 0, 1);
    repeat (5) drive(15'b000000000000101, 1, 0);
    idle(6);
    drive('0, 0, 1); idle(3);

    drive('0, 0, 1);
    drive(therm_of(3), 1, 0); drive(therm_of(4), 1, 0);
    drive(therm_of(4), 1, 0); drive(therm_of(5), 1, 0); idle(6);
    drive(therm_of(0), 1, 0); drive(therm_of(0), 1, 0);
    drive(therm_of(0), 1, 0); drive(therm_of(3), 1, 0); idle(6);

    drive('0, 0, 1);
    drive(therm_of(9), 1, 0); drive(therm_of(13), 1, 0); idle(6);
    drive('0, 0, 1);
    repeat (4) drive(therm_of(4), 1, 0);
    idle(6);

    drive(therm_of(9), 1, 0); drive(therm_of(13), 1, 0); idle(6);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    repeat (4) drive(therm_of(4), 1, 0);
    idle(6);

    drive(therm_of(5), 1, 1); idle(6);

    for (int i = 0; i < 400; i++) begin
      if (i % 8 == 0) bubble_en = 1'($urandom_range(0, 1));
      drive(rand_therm(), $urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0);
    end
    idle(10);

    check("pass_pending", exp_pass.size(), 0);
    check("avg_pending", exp_avg.size(), 0);
    check("model_pipe_pending", pipe_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
